// File: rtl/alu_exec_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared definitions for the ALU execution stage:
//   - op-select encodings driven onto au_sel
//   - bit positions of the {N,Z,V,C} flag vector
//   - FSM state type of the stage controller
// ---------------------------------------------------------------------------
package alu_exec_stage_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_V = 1;
    localparam int F_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_sat_clamp.sv
// ---------------------------------------------------------------------------
// alu_sat_clamp
// Combinational signed saturation of the arithmetic unit result. Used only
// when the stage is built with ALU_EXEC_SAT_EN.
// Ports:
//   a_msb     in   sign bit of operand A (direction of the clamp)
//   res_in    in   raw result from the arithmetic unit
//   nzvc_in   in   raw {N,Z,V,C} flags from the arithmetic unit
//   res_out   out  result, clamped to 0x7F/0x80 when V is set
//   nzvc_out  out  flags; N/Z refreshed from the clamped value, V/C untouched
// ---------------------------------------------------------------------------
module alu_sat_clamp
    import alu_exec_stage_pkg::*;
#(
    parameter int W  = 8,
    parameter int FW = 4
) (
    input  logic          a_msb,
    input  logic [W-1:0]  res_in,
    input  logic [FW-1:0] nzvc_in,
    output logic [W-1:0]  res_out,
    output logic [FW-1:0] nzvc_out
);

    // Clamp toward the sign of A on overflow and refresh N/Z for the clamped value
    always_comb begin
        res_out  = res_in;
        nzvc_out = nzvc_in;
        if (nzvc_in[F_V]) begin
            res_out       = a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            nzvc_out[F_N] = res_out[W-1];
            nzvc_out[F_Z] = (res_out == {W{1'b0}});
        end else begin
            res_out  = res_in;
            nzvc_out = nzvc_in;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Registered execution stage around an external combinational 8-bit
// arithmetic unit. One operation in flight: IDLE accepts a request and
// registers the unit operands, EXEC captures the unit outputs into the
// result/flag registers (and optionally the accumulator), DONE presents
// the result until the downstream takes it.
// Optional feature: define ALU_EXEC_SAT_EN to saturate the captured result
// on signed overflow (see alu_sat_clamp).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               request handshake
//   in_a, in_b, in_sel              operands and op select
//   in_use_acc, in_wr_acc           take A from / write result to accumulator
//   au_a, au_b, au_sel              registered operands to the unit
//   au_result, au_nzvc              combinational outputs of the unit
//   out_valid/out_ready             result handshake
//   out_result, out_nzvc            registered result and flags
//   acc                             accumulator
// ---------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int W  = 8,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [1:0]    in_sel,
    input  logic          in_use_acc,
    input  logic          in_wr_acc,
    output logic [W-1:0]  au_a,
    output logic [W-1:0]  au_b,
    output logic [1:0]    au_sel,
    input  logic [W-1:0]  au_result,
    input  logic [FW-1:0] au_nzvc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [FW-1:0] out_nzvc,
    output logic [W-1:0]  acc
);

    state_e        state_q, state_d;
    logic [W-1:0]  au_a_q, au_a_d;
    logic [W-1:0]  au_b_q, au_b_d;
    logic [1:0]    au_sel_q, au_sel_d;
    logic          wr_acc_q, wr_acc_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  out_result_q, out_result_d;
    logic [FW-1:0] out_nzvc_q, out_nzvc_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    // Value actually captured at the end of EXEC
    logic [W-1:0]  cap_result;
    logic [FW-1:0] cap_nzvc;

`ifdef ALU_EXEC_SAT_EN
    alu_sat_clamp #(
        .W  (W),
        .FW (FW)
    ) u_sat_clamp (
        .a_msb    (au_a_q[W-1]),
        .res_in   (au_result),
        .nzvc_in  (au_nzvc),
        .res_out  (cap_result),
        .nzvc_out (cap_nzvc)
    );
`else
    assign cap_result = au_result;
    assign cap_nzvc   = au_nzvc;
`endif

    // Next-state and next-register computation for the stage controller
    always_comb begin
        state_d      = state_q;
        au_a_d       = au_a_q;
        au_b_d       = au_b_q;
        au_sel_d     = au_sel_q;
        wr_acc_d     = wr_acc_q;
        acc_d        = acc_q;
        out_result_d = out_result_q;
        out_nzvc_d   = out_nzvc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    au_a_d   = in_use_acc ? acc_q : in_a;
                    au_b_d   = in_b;
                    au_sel_d = in_sel;
                    wr_acc_d = in_wr_acc;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // au_* has been stable for this whole cycle, so the unit has settled
                out_result_d = cap_result;
                out_nzvc_d   = cap_nzvc;
                if (wr_acc_q) begin
                    acc_d = cap_result;
                end else begin
                    acc_d = acc_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next state decode
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            au_a_q       <= {W{1'b0}};
            au_b_q       <= {W{1'b0}};
            au_sel_q     <= 2'b00;
            wr_acc_q     <= 1'b0;
            acc_q        <= {W{1'b0}};
            out_result_q <= {W{1'b0}};
            out_nzvc_q   <= {FW{1'b0}};
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            au_a_q       <= au_a_d;
            au_b_q       <= au_b_d;
            au_sel_q     <= au_sel_d;
            wr_acc_q     <= wr_acc_d;
            acc_q        <= acc_d;
            out_result_q <= out_result_d;
            out_nzvc_q   <= out_nzvc_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign au_a       = au_a_q;
    assign au_b       = au_b_q;
    assign au_sel     = au_sel_q;
    assign out_result = out_result_q;
    assign out_nzvc   = out_nzvc_q;
    assign acc        = acc_q;

endmodule
